// File: rtl/agua_pkg.sv
// Shared definitions for the water-path sequencer: state codes, counter width
// and the level-sensor consistency check.
package agua_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] ST_REPOSO   = 3'd0;
  localparam logic [2:0] ST_REGANDO  = 3'd1;
  localparam logic [2:0] ST_ESPERA   = 3'd2;
  localparam logic [2:0] ST_LLENANDO = 3'd3;
  localparam logic [2:0] ST_FALLA    = 3'd4;

  // High sensor wet while the low one reads dry cannot happen physically.
  function automatic logic falla_sensor(input logic low_level, input logic high_level);
    return high_level & ~low_level;
  endfunction

endpackage

// File: rtl/tick_segundos.sv
// One-second tick generator; restart realigns the second boundary to the
// current cycle so each timed state starts on a fresh second.
module tick_segundos #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] pre;

  assign tick = (pre == PW'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/planificador_agua.sv
// Water-path sequencer: arbitrates pump and electrovalve on the shared supply,
// times watering, cooldown and tank refill, and flags tank alarms/faults.
module planificador_agua
  import agua_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int T_BASE        = 5,
  parameter int T_REPOSO      = 30,
  parameter int T_MAX_LLENADO = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       regar,
  input  logic [3:0] maceta,
  input  logic       mod_bomba,
  input  logic       mod_electrov,
  input  logic       low_level,
  input  logic       high_level,
  output logic       activar_b,
  output logic       activar_ev,
  output logic       alarma_tanque,
  output logic       error_llenado,
  output logic [2:0] estado
);

  if ((15 * T_BASE > 65535) || (T_REPOSO > 65535) || (T_MAX_LLENADO > 65535)) begin : g_chk_ancho
    $error("planificador_agua: timing parameter does not fit the 16-bit seconds counter");
  end

  logic [4:0] meta, sinc;
  logic       s_regar, s_bomba, s_ev, s_low, s_high, falla;
  logic [2:0] state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic       tick, entrada, fin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      sinc <= '0;
    end else begin
      meta <= {regar, mod_bomba, mod_electrov, low_level, high_level};
      sinc <= meta;
    end
  end

  assign {s_regar, s_bomba, s_ev, s_low, s_high} = sinc;
  assign falla   = falla_sensor(s_low, s_high);
  assign entrada = (state_nx != state);
  // Last tick of the last second: leaving here makes the state last N*CLK_HZ cycles.
  assign fin     = tick && (cnt <= CNT_W'(1));

  tick_segundos #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (entrada),
    .tick    (tick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_REPOSO: begin
        if (falla)                                       state_nx = ST_FALLA;
        else if (s_ev && !s_low)                         state_nx = ST_LLENANDO;
        else if (s_regar && s_bomba && s_low && maceta != 4'd0) state_nx = ST_REGANDO;
      end
      ST_REGANDO: begin
        if (falla)         state_nx = ST_FALLA;
        else if (!s_low)   state_nx = s_ev ? ST_LLENANDO : ST_REPOSO;
        else if (!s_bomba) state_nx = ST_REPOSO;
        else if (fin)      state_nx = ST_ESPERA;
      end
      ST_ESPERA: begin
        if (falla)               state_nx = ST_FALLA;
        else if (!s_low && s_ev) state_nx = ST_LLENANDO;
        else if (fin)            state_nx = ST_REPOSO;
      end
      ST_LLENANDO: begin
        if (falla)       state_nx = ST_FALLA;
        else if (s_high) state_nx = ST_REPOSO;
        else if (!s_ev)  state_nx = ST_REPOSO;
        else if (fin)    state_nx = ST_FALLA;
      end
      ST_FALLA: begin
        if (!s_ev && !falla) state_nx = ST_REPOSO;
      end
      default: state_nx = ST_REPOSO;
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (entrada) begin
      case (state_nx)
        ST_REGANDO:  cnt_nx = CNT_W'(maceta) * CNT_W'(T_BASE);
        ST_ESPERA:   cnt_nx = CNT_W'(T_REPOSO);
        ST_LLENANDO: cnt_nx = CNT_W'(T_MAX_LLENADO);
        default:     cnt_nx = '0;
      endcase
    end else if (tick && cnt != '0) begin
      cnt_nx = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_REPOSO;
      cnt           <= '0;
      activar_b     <= 1'b0;
      activar_ev    <= 1'b0;
      alarma_tanque <= 1'b0;
      error_llenado <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      activar_b     <= (state_nx == ST_REGANDO);
      activar_ev    <= (state_nx == ST_LLENANDO);
      alarma_tanque <= (state_nx == ST_LLENANDO) || (state_nx == ST_FALLA) || (!s_low && !s_ev);
      error_llenado <= (state_nx == ST_FALLA);
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_planificador_agua.sv
// Directed and random stimulus for planificador_agua, checked every cycle
// against a cycle-countdown reference model of the sequencing rules.
module tb_planificador_agua;

  localparam int CLK_HZ = 4;
  localparam int T_BASE = 2;
  localparam int T_REP  = 3;
  localparam int T_MAX  = 5;

  logic       clk = 1'b0;
  logic       rst_n, regar, mod_bomba, mod_electrov, low_level, high_level;
  logic [3:0] maceta;
  logic       activar_b, activar_ev, alarma_tanque, error_llenado;
  logic [2:0] estado;

  int total = 0;
  int bad   = 0;

  // reference model: state, cycles left in it, 2-deep input delay line
  int         m_st = 0;
  int         m_rem = 0;
  logic [4:0] d1 = '0, d2 = '0;
  logic       e_b, e_ev, e_al, e_err;
  int         e_est;

  always #5 clk = ~clk;

  planificador_agua #(
    .CLK_HZ(CLK_HZ), .T_BASE(T_BASE), .T_REPOSO(T_REP), .T_MAX_LLENADO(T_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .regar(regar), .maceta(maceta),
    .mod_bomba(mod_bomba), .mod_electrov(mod_electrov),
    .low_level(low_level), .high_level(high_level),
    .activar_b(activar_b), .activar_ev(activar_ev),
    .alarma_tanque(alarma_tanque), .error_llenado(error_llenado), .estado(estado)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic r, bo, ev, lo, hi, flt, last;
    int nxt;
    if (!rst_n) begin
      m_st = 0; m_rem = 0; d1 = '0; d2 = '0;
      e_b = 0; e_ev = 0; e_al = 0; e_err = 0; e_est = 0;
      return;
    end
    {r, bo, ev, lo, hi} = d2;
    flt  = hi && !lo;
    last = (m_rem == 1);
    nxt  = m_st;
    case (m_st)
      0: if (flt) nxt = 4;
         else if (ev && !lo) nxt = 3;
         else if (r && bo && lo && maceta != 0) nxt = 1;
      1: if (flt) nxt = 4;
         else if (!lo) nxt = ev ? 3 : 0;
         else if (!bo) nxt = 0;
         else if (last) nxt = 2;
      2: if (flt) nxt = 4;
         else if (!lo && ev) nxt = 3;
         else if (last) nxt = 0;
      3: if (flt) nxt = 4;
         else if (hi) nxt = 0;
         else if (!ev) nxt = 0;
         else if (last) nxt = 4;
      default: if (!ev && !flt) nxt = 0;
    endcase
    if (nxt != m_st)
      m_rem = (nxt == 1) ? int'(maceta) * T_BASE * CLK_HZ :
              (nxt == 2) ? T_REP * CLK_HZ :
              (nxt == 3) ? T_MAX * CLK_HZ : 0;
    else if (m_rem > 0)
      m_rem--;
    m_st  = nxt;
    e_est = nxt;
    e_b   = (nxt == 1);
    e_ev  = (nxt == 3);
    e_err = (nxt == 4);
    e_al  = (nxt == 3) || (nxt == 4) || (!lo && !ev);
    d2 = d1;
    d1 = {regar, mod_bomba, mod_electrov, low_level, high_level};
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("estado", 16'(estado), 16'(e_est));
    chk("activar_b", 16'(activar_b), 16'(e_b));
    chk("activar_ev", 16'(activar_ev), 16'(e_ev));
    chk("alarma_tanque", 16'(alarma_tanque), 16'(e_al));
    chk("error_llenado", 16'(error_llenado), 16'(e_err));
    chk("exclusion", 16'(activar_b & activar_ev), 16'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    rst_n = 0; regar = 0; mod_bomba = 0; mod_electrov = 0;
    low_level = 0; high_level = 0; maceta = 0;
    steps(2);
    chk("reset_estado", 16'(estado), 16'd0);
    chk("reset_b", 16'(activar_b), 16'd0);

    rst_n = 1; low_level = 1; mod_bomba = 1; maceta = 3;
    steps(4);

    // normal watering: single-cycle regar pulse
    regar = 1; step(); regar = 0;
    step();
    chk("riego_lat2", 16'(activar_b), 16'd0);
    step();
    chk("riego_lat3", 16'(activar_b), 16'd1);
    n = 0;
    while (activar_b && n < 100) begin n++; step(); end
    chk("riego_dur", 16'(n), 16'd24);
    n = 0;
    while (estado == 3'd2 && n < 100) begin n++; step(); end
    chk("espera_dur", 16'(n), 16'd12);
    chk("espera_fin", 16'(estado), 16'd0);

    // tank runs dry on cycle 10 of watering
    mod_electrov = 1; regar = 1;
    steps(3);
    chk("riego2_on", 16'(activar_b), 16'd1);
    regar = 0;
    steps(9);
    low_level = 0;
    steps(2);
    chk("vacio_lat2_b", 16'(activar_b), 16'd1);
    step();
    chk("vacio_b", 16'(activar_b), 16'd0);
    chk("vacio_ev", 16'(activar_ev), 16'd1);

    // refill completes after 8 cycles
    steps(7);
    high_level = 1; low_level = 1;
    steps(2);
    chk("lleno_lat2", 16'(activar_ev), 16'd1);
    step();
    chk("lleno_ev", 16'(activar_ev), 16'd0);
    chk("lleno_estado", 16'(estado), 16'd0);
    chk("lleno_alarma", 16'(alarma_tanque), 16'd0);

    // refill timeout
    low_level = 0; high_level = 0;
    steps(3);
    chk("tmo_inicio", 16'(estado), 16'd3);
    n = 0;
    while (estado == 3'd3 && n < 100) begin n++; step(); end
    chk("tmo_dur", 16'(n), 16'd20);
    chk("tmo_estado", 16'(estado), 16'd4);
    chk("tmo_error", 16'(error_llenado), 16'd1);
    steps(5);
    chk("tmo_retiene", 16'(error_llenado), 16'd1);
    mod_electrov = 0;
    steps(3);
    chk("tmo_salida", 16'(estado), 16'd0);
    chk("tmo_alarma", 16'(alarma_tanque), 16'd1);

    // inconsistent sensors
    high_level = 1;
    steps(3);
    chk("sensor_falla", 16'(estado), 16'd4);
    high_level = 0; low_level = 1;
    steps(3);
    chk("sensor_ok", 16'(estado), 16'd0);

    // guards: no pot, no pump module
    maceta = 0; regar = 1;
    steps(8);
    chk("sin_maceta", 16'(estado), 16'd0);
    maceta = 5; mod_bomba = 0;
    steps(8);
    chk("sin_bomba", 16'(activar_b), 16'd0);

    // reset mid-watering, regar still high
    mod_bomba = 1; maceta = 2;
    steps(3);
    chk("rst_pre", 16'(activar_b), 16'd1);
    steps(5);
    rst_n = 0;
    step();
    chk("rst_b", 16'(activar_b), 16'd0);
    chk("rst_estado", 16'(estado), 16'd0);
    rst_n = 1;
    steps(2);
    chk("rst_lat2", 16'(activar_b), 16'd0);
    step();
    chk("rst_rearranque", 16'(activar_b), 16'd1);
    n = 0;
    while (activar_b && n < 100) begin n++; step(); end
    chk("rst_dur", 16'(n), 16'd16);
    regar = 0;

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) regar        = ~regar;
      if ($urandom_range(0, 40) == 0) mod_bomba    = ~mod_bomba;
      if ($urandom_range(0, 30) == 0) mod_electrov = ~mod_electrov;
      if ($urandom_range(0, 25) == 0) low_level    = ~low_level;
      if ($urandom_range(0, 25) == 0) high_level   = ~high_level;
      if ($urandom_range(0, 20) == 0) maceta       = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/planificador_agua.md
# planificador_agua

Sequencer for the water path: it owns the pump and electrovalve enables and decides which one runs. Requesters are the watering request from the humidity comparator and the tank-empty condition from the level sensors. The block enforces mutual exclusion (one shared 12 V supply), pot-size-based watering time, a post-watering cooldown and a tank-refill timeout. It sits between the humidity/decoder logic and the actuator pins, and feeds the tank-alarm request to the melody selection.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock cycles per second (prescaler terminal count)
- T_BASE, 5, watering seconds per unit of `maceta`
- T_REPOSO, 30, cooldown seconds after a completed watering
- T_MAX_LLENADO, 600, refill timeout in seconds

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- regar  in  1  watering request (level)
- maceta  in  4  pot size code; 0 = no pot
- mod_bomba  in  1  pump module present
- mod_electrov  in  1  electrovalve module present
- low_level  in  1  1 = tank at or above 5 %
- high_level  in  1  1 = tank at or above 90 %
- activar_b  out  1  pump enable
- activar_ev  out  1  valve enable
- alarma_tanque  out  1  request for the tank melody
- error_llenado  out  1  refill timeout or sensor fault
- estado  out  3  current state code, for the display/UART

## Operation
- All five inputs except `maceta` pass through 2-flop synchronizers. `maceta` is sampled only on entry to REGANDO.
- State codes: REPOSO=0, REGANDO=1, ESPERA=2, LLENANDO=3, FALLA=4.
- A 16-bit seconds counter `cnt` is loaded on every state entry. It decrements on each prescaler tick.
- REPOSO transitions, in priority order:
  - sensor fault (high_level=1 and low_level=0) → FALLA
  - mod_electrov=1 and low_level=0 → LLENANDO, cnt=T_MAX_LLENADO
  - regar=1, mod_bomba=1, low_level=1 and maceta≠0 → REGANDO, cnt=maceta×T_BASE
- REGANDO (activar_b=1) transitions:
  - sensor fault → FALLA
  - low_level=0 → LLENANDO if mod_electrov=1, else REPOSO
  - mod_bomba=0 → REPOSO
  - cnt reaches 0 → ESPERA, cnt=T_REPOSO
- `regar` dropping mid-watering does not abort; the full dose is delivered.
- ESPERA transitions:
  - sensor fault → FALLA
  - low_level=0 and mod_electrov=1 → LLENANDO
  - cnt reaches 0 → REPOSO
- `regar` is ignored in ESPERA.
- LLENANDO (activar_ev=1) transitions:
  - sensor fault → FALLA
  - high_level=1 → REPOSO
  - mod_electrov=0 → REPOSO
  - cnt reaches 0 → FALLA
- FALLA: both enables 0, error_llenado=1. Exits to REPOSO only when mod_electrov=0 and the sensor pair is consistent.
- Invariant: activar_b and activar_ev are never 1 in the same cycle.
- alarma_tanque = 1 when in LLENANDO or FALLA, or when low_level=0 with mod_electrov=0.
- All outputs are registered and decoded from the next-state value.
- Width rule: 15×T_BASE, T_REPOSO and T_MAX_LLENADO must each be ≤ 65535. Elaboration-time check required.

## Timing
- Reset (rst_n=0 at a clk edge): state=REPOSO, all outputs 0, cnt=0, prescaler=0, synchronizer flops cleared to 0.
- Input edge to output change: exactly 3 cycles (2 synchronizer stages plus 1 state register).
- The prescaler restarts at 0 on every state entry; a tick fires when it reaches CLK_HZ−1.
- A state timed for N seconds lasts exactly N×CLK_HZ cycles, then the exit transition is taken.
- Timeout or completion coinciding with an abort condition in the same cycle: the abort/fault transition wins.
- Reset mid-operation drops both enables on the cycle after the reset edge. No residual count survives reset.

## Structure
- Shared package `agua_pkg` holds:
  - state codes
  - counter width (16)
  - the sensor-fault predicate as a function
- Sub-module `tick_segundos`:
  - inputs clk, rst_n, restart
  - output tick
  - parameter CLK_HZ
- FSM, counter and output registers live in `planificador_agua`.

## Test plan
All scenarios use CLK_HZ=4, T_BASE=2, T_REPOSO=3, T_MAX_LLENADO=5.
- Normal watering: maceta=3, regar pulse, low_level=1, mod_bomba=1 → activar_b high 3 cycles after regar, for exactly 24 cycles. Then estado=2 for 12 cycles, then estado=0.
- Empty tank during watering: low_level→0 at cycle 10 of REGANDO with mod_electrov=1 → activar_b falls and activar_ev rises on the same cycle, 3 cycles after the edge. Enables never overlap.
- Refill complete: estado=3, high_level→1 after 8 cycles → activar_ev drops 3 cycles later; estado=0; alarma_tanque=0.
- Refill timeout: high_level held 0 → after 20 cycles in LLENANDO, estado=4, error_llenado=1. Holds until mod_electrov=0, then REPOSO.
- Sensor fault and guards:
  - high_level=1 with low_level=0 in REPOSO → FALLA.
  - maceta=0 with regar=1 → stays REPOSO.
  - mod_bomba=0 → no pump.
- Reset mid-REGANDO: rst_n low one edge → all outputs 0 and estado=0 on the next cycle. Watering restarts with the full count if regar is still high.
